lc3b_mem_responder: RTL
=======================

// Module: lc3b_mem_responder
// PURPOSE
//  Memory-side responder for the LC-3b CPU memory port; the far end of the MDR/byte-lane path.
//  Accepts word/byte read and write requests, waits a fixed latency, then commits or returns data.
//  Byte stores arrive lane-placed (low byte for even address, high byte for odd) and are merged
//  into the stored word under byte enables. Serves as the memory behind the datapath in sims/FPGA.
// PARAMETERS
//  ADDR_BITS  8  word-index width; array holds 2**ADDR_BITS 16-bit words
//  LATENCY    3  cycles from request acceptance to mem_resp; legal range 1..15
// PORTS
//  clk              in   1   single clock, rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  mem_read         in   1   read request, held by CPU until mem_resp
//  mem_write        in   1   write request, held by CPU until mem_resp
//  mem_byte_enable  in   2   lane enables: [0]=bits 7:0, [1]=bits 15:8
//  mem_address      in   16  byte address (lc3b_word)
//  mem_wdata        in   16  write data, already lane-placed (lc3b_word)
//  mem_rdata        out  16  read data, full word (lc3b_word)
//  mem_resp         out  1   one-cycle completion pulse
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, mem_resp 0, mem_rdata 16'h0000. Array contents not reset.
//  - Word index = mem_address[ADDR_BITS:1]; bit 0 and bits above ADDR_BITS ignored (aliasing).
//  - FSM states: IDLE, BUSY, RESP.
//  - IDLE: mem_read|mem_write high at edge -> latch address, wdata, byte_enable, op;
//    counter <= LATENCY-1; go BUSY. Both high = protocol error, treated as write.
//  - BUSY: counter==0 -> perform access, mem_resp <= 1, go RESP; else decrement.
//    mem_resp is therefore high exactly LATENCY+1 cycles after the request is first seen in IDLE.
//  - RESP: mem_resp high this cycle only; next edge -> IDLE, mem_resp <= 0.
//    CPU drops its request at that same edge; a new request is seen in the IDLE cycle that follows.
//  - Write commit: word[i] <= lane_merge(old, wdata, be).
//    be=2'b00 is a no-op commit but still responds.
//  - Read: mem_rdata <= word[i] at commit regardless of be.
//    mem_rdata holds until the next read commit; writes never alter it.
//  - Inputs changing or dropping during BUSY are ignored: latched values complete, writes still commit.
//  - Reset asserted mid-transaction: abort immediately to IDLE, no commit, mem_resp 0.
//  - No pipelining: one outstanding request; requests arriving in BUSY/RESP are not queued.
// STRUCTURE
//  - lc3b_types package: lc3b_word (existing), new typedef lc3b_mem_wmask = logic [1:0].
//  - Sub-module lane_merge (combinational): out = {be[1]?new[15:8]:old[15:8], be[0]?new[7:0]:old[7:0]}.
//  - Top holds FSM, latency counter, request latches and the word array.
// TESTING
//  1. Reset mid-BUSY of write 16'hBEEF @x0010 -> mem_resp stays 0; read x0010 returns prior value.
//  2. Write 16'hBEEF @x0010 be=11, then read @x0010 -> mem_rdata=16'hBEEF;
//     mem_resp 1 cycle, LATENCY+1 cycles after request.
//  3. After 2, byte write wdata=16'h0012 @x0010 be=01, then byte write 16'h3400 @x0011 be=10;
//     read -> 16'h3412.
//  4. Write be=00 data 16'hFFFF @x0010 -> resp pulses; later read returns 16'h3412.
//  5. Drop mem_read 1 cycle after acceptance -> mem_resp still fires, mem_rdata updated.
//     Back-to-back read/write: each gets one pulse, none lost.
//  6. LATENCY=1 build: resp 2 cycles after request.
//     Address x0210 aliases x0010 with ADDR_BITS=8; mem_read+mem_write together act as write.

Source files
------------

// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b types for the memory responder: data word, byte-lane mask and FSM states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/lc3b_mem_responder_lane_merge.sv
// Byte-lane merge: each enabled lane takes the new byte, disabled lanes keep the stored byte.
module lane_merge
  import lc3b_types::*;
(
  input  lc3b_word      i_old,
  input  lc3b_word      i_new,
  input  lc3b_mem_wmask i_be,
  output lc3b_word      o_out
);

  assign o_out = {i_be[1] ? i_new[15:8] : i_old[15:8],
                  i_be[0] ? i_new[7:0]  : i_old[7:0]};

endmodule

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency word/byte memory behind the LC-3b memory port: one outstanding request,
// latched at acceptance, committed after LATENCY cycles with a one-cycle mem_resp pulse.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 3
)
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output lc3b_word      mem_rdata,
  output logic          mem_resp
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  mem_state_e           r_state;
  mem_state_e           w_next_state;
  logic [3:0]           r_count;
  logic [ADDR_BITS-1:0] r_index;
  lc3b_word             r_wdata;
  lc3b_mem_wmask        r_be;
  logic                 r_is_write;
  lc3b_word             r_rdata;
  logic                 r_resp;
  lc3b_word             r_mem [DEPTH];

  logic                 w_accept;
  logic                 w_commit;
  lc3b_word             w_merged;
  logic                 w_unused;

  // Byte-address bit 0 and the bits above the word index alias onto the same words.
  assign w_unused = ^{mem_address[0], mem_address[15:ADDR_BITS+1]};

  assign w_accept = (r_state == IDLE) && (mem_read || mem_write);
  assign w_commit = (r_state == BUSY) && (r_count == 4'd0);

  lane_merge u_lane_merge (
    .i_old (r_mem[r_index]),
    .i_new (r_wdata),
    .i_be  (r_be),
    .o_out (w_merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (mem_read || mem_write) w_next_state = BUSY;
      BUSY:    if (r_count == 4'd0)       w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Read+write together is a protocol error and is serviced as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= 4'd0;
      r_index    <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_is_write <= 1'b0;
      r_rdata    <= 16'h0000;
      r_resp     <= 1'b0;
    end else begin
      r_resp <= w_commit;
      if (w_accept) begin
        r_count    <= 4'(LATENCY - 1);
        r_index    <= mem_address[ADDR_BITS:1];
        r_wdata    <= mem_wdata;
        r_be       <= mem_byte_enable;
        r_is_write <= mem_write;
      end else if ((r_state == BUSY) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
      if (w_commit && !r_is_write) begin
        r_rdata <= r_mem[r_index];
      end
    end
  end

  // Array contents survive reset; an aborted request never reaches commit.
  always_ff @(posedge clk) begin
    if (w_commit && r_is_write) begin
      r_mem[r_index] <= w_merged;
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_resp  = r_resp;

endmodule
